// File: rtl/copper_reg_target_pkg.sv
// copper_reg_target_pkg
// Shared types and constants for the copper register target:
//   - handshake FSM state encoding
//   - address-region codes decoded from adr[7:6]
//   - control/status register offsets within the 256-byte window
//   - byte-lane merge helper used for pending/active writes
package copper_reg_target_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    localparam logic [1:0] REGION_PEND = 2'd0;
    localparam logic [1:0] REGION_ACT  = 2'd1;
    localparam logic [1:0] REGION_CTRL = 2'd2;
    localparam logic [1:0] REGION_STAT = 2'd3;

    localparam logic [7:0] CTRL_IMM_OFS   = 8'h80;
    localparam logic [7:0] CTRL_FORCE_OFS = 8'h84;
    localparam logic [7:0] STAT_OFS       = 8'hC0;

    // Replace only the bytes whose lane select is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/copper_reg_target_if.sv
// copper_reg_target_if
// Single-beat bus between the copper/CPU master and the register target.
//   cyc_i/stb_i : cycle valid / strobe          (master -> slave)
//   we_i        : write enable                  (master -> slave)
//   sel_i[3:0]  : byte lane selects             (master -> slave)
//   adr_i[31:0] : byte address                  (master -> slave)
//   dat_i[31:0] : write data                    (master -> slave)
//   ack_o       : acknowledge                   (slave -> master)
//   dat_o[31:0] : read data, zero when not acked (slave -> master)
interface copper_reg_target_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic        ack_o;
    logic [31:0] dat_o;

    modport master (
        output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        input  ack_o, dat_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        output ack_o, dat_o
    );
endinterface

// File: rtl/copper_reg_target_sync_edge.sv
// copper_reg_target_sync_edge (sync_edge)
// Two-flop synchronizer followed by a rising-edge detector. Usable for any
// slow asynchronous strobe (vsync, hsync).
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input
//   rise_o : one-cycle pulse, combinational from the flops, high the cycle
//            after the second synchronizer stage first captures a 1
module copper_reg_target_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);
    // [0],[1] synchronizer stages, [2] previous value for edge detection
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], d_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= sync_d;
    end

    assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/copper_reg_target.sv
// copper_reg_target
// Bus responder for copper MOVE writes and CPU accesses into a double-buffered
// bank of video control registers. Writes land in the pending bank; the
// pending bank is committed into the active bank on vsync rising edge or on a
// force-commit write. Immediate mode writes both banks at once.
//   clk_i    : bus and register clock
//   rst_ni   : asynchronous active-low reset
//   vsync_i  : vertical sync, asynchronous to clk_i
//   bus      : slave side of copper_reg_target_if
//   regs_o   : active bank, register n at [32n+31:32n]
//   commit_o : one-cycle pulse per commit
//   dirty_o  : pending-bank dirty mask
//
// state  | meaning
// S_IDLE | waiting for a selected cyc/stb; access performed on leaving
// S_ACK  | ack_o high, dat_o valid; held until cyc or stb drops
module copper_reg_target
    import copper_reg_target_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFD200000,
    parameter int          NREGS     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  vsync_i,
    copper_reg_target_if.slave    bus,
    output logic [NREGS*32-1:0]   regs_o,
    output logic                  commit_o,
    output logic [NREGS-1:0]      dirty_o
);
    state_t             state_q, state_d;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;
    logic               commit_q, commit_d;
    logic               imm_q, imm_d;
    logic [NREGS-1:0]   dirty_q, dirty_d;
    logic [31:0]        pend_q [NREGS];
    logic [31:0]        pend_d [NREGS];
    logic [31:0]        act_q  [NREGS];
    logic [31:0]        act_d  [NREGS];

    logic        vsync_rise;
    logic        cs, req, access, wr, force_c, commit_c;
    logic [1:0]  region;
    logic [3:0]  idx;
    logic [5:0]  ofs;
    logic [31:0] rdata;
    logic        unused_adr;

    copper_reg_target_sync_edge u_vsync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (vsync_i),
        .rise_o (vsync_rise)
    );

    assign cs         = (bus.adr_i[31:8] == BASE_ADDR[31:8]);
    assign region     = bus.adr_i[7:6];
    assign idx        = bus.adr_i[5:2];
    assign ofs        = bus.adr_i[7:2];
    assign req        = bus.cyc_i & bus.stb_i;
    assign access     = (state_q == S_IDLE) & req & cs;
    assign wr         = access & bus.we_i;
    assign unused_adr = ^bus.adr_i[1:0];

    always_comb begin
        rdata = '0;
        case (region)
            REGION_PEND: rdata = pend_q[idx];
            REGION_ACT:  rdata = act_q[idx];
            REGION_CTRL: if (ofs == CTRL_IMM_OFS[7:2]) rdata = {31'd0, imm_q};
            REGION_STAT: if (ofs == STAT_OFS[7:2])     rdata = 32'(dirty_q);
            default:     rdata = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        dat_d   = dat_q;
        imm_d   = imm_q;
        dirty_d = dirty_q;
        pend_d  = pend_q;
        act_d   = act_q;

        case (state_q)
            S_IDLE: begin
                if (access) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    dat_d   = bus.we_i ? 32'd0 : rdata;
                end
            end
            S_ACK: begin
                if (!req) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b0;
                    dat_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A force-commit and a vsync edge in the same cycle merge into one commit.
        force_c  = wr && (region == REGION_CTRL) && (ofs == CTRL_FORCE_OFS[7:2]) && bus.dat_i[0];
        commit_c = vsync_rise | force_c;
        commit_d = commit_c;

        // Commit copies pre-write pending values; a coincident write below
        // re-sets its dirty bit so it survives until the next frame.
        if (commit_c) begin
            for (int n = 0; n < NREGS; n++) begin
                if (dirty_q[n]) act_d[n] = pend_q[n];
            end
            dirty_d = '0;
        end

        if (wr) begin
            case (region)
                REGION_PEND: begin
                    pend_d[idx] = byte_merge(pend_q[idx], bus.dat_i, bus.sel_i);
                    if (imm_q) act_d[idx] = byte_merge(act_d[idx], bus.dat_i, bus.sel_i);
                    else       dirty_d[idx] = 1'b1;
                end
                REGION_CTRL: begin
                    if (ofs == CTRL_IMM_OFS[7:2]) imm_d = bus.dat_i[0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            commit_q <= 1'b0;
            imm_q    <= 1'b0;
            dirty_q  <= '0;
            for (int n = 0; n < NREGS; n++) begin
                pend_q[n] <= '0;
                act_q[n]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            commit_q <= commit_d;
            imm_q    <= imm_d;
            dirty_q  <= dirty_d;
            pend_q   <= pend_d;
            act_q    <= act_d;
        end
    end

    always_comb begin
        regs_o = '0;
        for (int n = 0; n < NREGS; n++) regs_o[32*n +: 32] = act_q[n];
    end

    assign bus.ack_o = ack_q;
    assign bus.dat_o = dat_q;
    assign commit_o  = commit_q;
    assign dirty_o   = dirty_q;
endmodule

// File: tb/tb_copper_reg_target.sv
module tb_copper_reg_target;
    localparam logic [31:0] BASE = 32'hFD200000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         vsync = 1'b0;
    logic [511:0] regs;
    logic         commit;
    logic [15:0]  dirty;

    int total = 0;
    int bad   = 0;
    int commit_cnt = 0;
    logic [511:0] ack_regs;

    copper_reg_target_if bus ();

    copper_reg_target #(.BASE_ADDR(BASE), .NREGS(16)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .vsync_i  (vsync),
        .bus      (bus),
        .regs_o   (regs),
        .commit_o (commit),
        .dirty_o  (dirty)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (commit) commit_cnt++;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        we;
        logic [7:0]  ofs;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    function automatic logic [31:0] reg_of(input logic [511:0] r, input int n);
        return r[32*n +: 32];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    // One bus transfer. lat = cycles until ack (20 if none arrived).
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat);
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we;
        bus.adr_i = adr;  bus.sel_i = sel;  bus.dat_i = wd;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!bus.ack_o && lat < 20);
        rd = bus.dat_o;
        ack_regs = regs;
        @(negedge clk);
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [7:0] ofs, input logic [3:0] sel, input logic [31:0] wd);
        logic [31:0] rd;
        int lat;
        xfer(1'b1, BASE | 32'(ofs), sel, wd, rd, lat);
        check($sformatf("write lat @%02h", ofs), 32'(lat), 32'd1);
    endtask

    task automatic rd_chk(input logic [7:0] ofs, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        xfer(1'b0, BASE | 32'(ofs), 4'hF, 32'd0, rd, lat);
        check($sformatf("read @%02h", ofs), rd, exp);
    endtask

    // Returns number of clk edges from vsync rise until commit_o seen.
    task automatic wait_commit(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!commit && cyc < 10);
    endtask

    vec_t vecs [14];

    initial begin
        logic [31:0] rd;
        int lat, cyc, c0;

        vecs[0]  = '{1'b1, 8'h08, 4'hF,    32'h12345678, 32'h0};
        vecs[1]  = '{1'b0, 8'h08, 4'hF,    32'h0,        32'h12345678};
        vecs[2]  = '{1'b0, 8'h48, 4'hF,    32'h0,        32'h0};
        vecs[3]  = '{1'b0, 8'hC0, 4'hF,    32'h0,        32'h00000004};
        vecs[4]  = '{1'b1, 8'h00, 4'b0011, 32'hAABBCCDD, 32'h0};
        vecs[5]  = '{1'b0, 8'h00, 4'hF,    32'h0,        32'h0000CCDD};
        vecs[6]  = '{1'b1, 8'h04, 4'b1100, 32'hAABBCCDD, 32'h0};
        vecs[7]  = '{1'b0, 8'h04, 4'hF,    32'h0,        32'hAABB0000};
        vecs[8]  = '{1'b0, 8'hC0, 4'hF,    32'h0,        32'h00000007};
        vecs[9]  = '{1'b0, 8'h80, 4'hF,    32'h0,        32'h0};
        vecs[10] = '{1'b0, 8'h84, 4'hF,    32'h0,        32'h0};
        vecs[11] = '{1'b1, 8'h44, 4'hF,    32'hFFFFFFFF, 32'h0};
        vecs[12] = '{1'b0, 8'h44, 4'hF,    32'h0,        32'h0};
        vecs[13] = '{1'b0, 8'hC0, 4'hF,    32'h0,        32'h00000007};

        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        bus.sel_i = 4'h0; bus.adr_i = '0;   bus.dat_i = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset ack", 32'(bus.ack_o), 32'd0);
        check("reset dat", bus.dat_o, 32'd0);
        check("reset commit", 32'(commit), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            xfer(vecs[i].we, BASE | 32'(vecs[i].ofs), vecs[i].sel, vecs[i].wd, rd, lat);
            check($sformatf("vec%0d lat", i), 32'(lat), 32'd1);
            check($sformatf("vec%0d rd", i), rd, vecs[i].exp_rd);
        end
        check("pre-commit reg2", reg_of(regs, 2), 32'h0);
        check("pre-commit dirty", 32'(dirty), 32'h7);

        // vsync commit latency and contents
        @(negedge clk) vsync = 1'b1;
        wait_commit(cyc);
        check("vsync commit latency", 32'(cyc), 32'd3);
        check("commit reg2", reg_of(regs, 2), 32'h12345678);
        check("commit reg0", reg_of(regs, 0), 32'h0000CCDD);
        check("commit reg1", reg_of(regs, 1), 32'hAABB0000);
        check("commit dirty", 32'(dirty), 32'h0);
        @(posedge clk); #1;
        check("commit one-cycle", 32'(commit), 32'd0);
        @(negedge clk) vsync = 1'b0;
        repeat (4) @(posedge clk);

        // immediate mode
        wr(8'h80, 4'hF, 32'h1);
        rd_chk(8'h80, 32'h1);
        c0 = commit_cnt;
        wr(8'h3C, 4'hF, 32'h55);
        check("imm reg15 at ack", reg_of(ack_regs, 15), 32'h55);
        check("imm dirty", 32'(dirty), 32'h0);
        check("imm no commit", 32'(commit_cnt - c0), 32'd0);
        wr(8'h80, 4'hF, 32'h0);

        // write coincident with vsync commit
        wr(8'h0C, 4'hF, 32'h11111111);
        c0 = commit_cnt;
        @(negedge clk) vsync = 1'b1;
        @(posedge clk);
        @(posedge clk);
        wr(8'h0C, 4'hF, 32'h22222222);
        check("coinc commits", 32'(commit_cnt - c0), 32'd1);
        check("coinc reg3 old", reg_of(regs, 3), 32'h11111111);
        check("coinc dirty3", 32'(dirty), 32'h0008);
        rd_chk(8'h0C, 32'h22222222);
        @(negedge clk) vsync = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) vsync = 1'b1;
        wait_commit(cyc);
        check("next frame latency", 32'(cyc), 32'd3);
        check("next frame reg3", reg_of(regs, 3), 32'h22222222);
        check("next frame dirty", 32'(dirty), 32'h0);
        @(negedge clk) vsync = 1'b0;
        repeat (4) @(posedge clk);

        // force commit
        wr(8'h14, 4'hF, 32'hCAFEF00D);
        c0 = commit_cnt;
        wr(8'h84, 4'hF, 32'h1);
        check("force commits", 32'(commit_cnt - c0), 32'd1);
        check("force reg5", reg_of(regs, 5), 32'hCAFEF00D);
        check("force dirty", 32'(dirty), 32'h0);

        // force commit coincident with vsync commit
        wr(8'h18, 4'hF, 32'h00000066);
        c0 = commit_cnt;
        @(negedge clk) vsync = 1'b1;
        @(posedge clk);
        @(posedge clk);
        wr(8'h84, 4'hF, 32'h1);
        repeat (4) @(posedge clk);
        #1;
        check("force+vsync single pulse", 32'(commit_cnt - c0), 32'd1);
        check("force+vsync reg6", reg_of(regs, 6), 32'h66);
        @(negedge clk) vsync = 1'b0;
        repeat (4) @(posedge clk);

        // out-of-window access
        xfer(1'b0, BASE + 32'h100, 4'hF, 32'h0, rd, lat);
        check("out-of-window no ack", 32'(lat), 32'd20);

        // reset during S_ACK
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
        bus.adr_i = BASE | 32'h08; bus.sel_i = 4'hF;
        @(posedge clk); #1;
        check("pre-reset ack", 32'(bus.ack_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset ack", 32'(bus.ack_o), 32'd0);
        check("async reset dat", bus.dat_o, 32'd0);
        check("reset regs nonzero", 32'(|regs), 32'd0);
        check("reset dirty", 32'(dirty), 32'd0);
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        rd_chk(8'h08, 32'h0);
        rd_chk(8'h80, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
